// File: rtl/rr_arbiter3.sv
// Round-robin arbiter sharing one AXI channel among three managers.
// Grant holds until finish (or watchdog expiry), then one dead GAP cycle precedes re-arbitration.
module rr_arbiter3 #(
  parameter int TMO_W   = 10,
  parameter int TMO_CYC = 1000,
  parameter bit TMO_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic [2:0] req_mask,
  input  logic       finish,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic [2:0] sel,
  output logic       busy,
  output logic       tmo_err,
  output logic [1:0] tmo_id
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_GAP = 2'd2} state_t;

  localparam logic [TMO_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             tmo_err_q, tmo_err_d;
  logic [1:0]       tmo_id_q, tmo_id_d;
  logic [2:0]       eff;
  logic [1:0]       pick_idx;

  // First effective requester found searching upward from the slot after the last grant.
  function automatic logic [1:0] rr_pick(input logic [2:0] reqs, input logic [1:0] last);
    logic [1:0] res;
    logic       found;
    int         c;
    res   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      c = (int'(last) + k) % 3;
      if (!found && reqs[c]) begin
        res   = 2'(c);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign eff      = {req2, req1, req0} & ~req_mask;
  assign pick_idx = rr_pick(eff, ptr_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    tmo_err_d = 1'b0;
    tmo_id_d  = tmo_id_q;
    case (state_q)
      S_IDLE: begin
        if (eff != 3'b000) begin
          gnt_d   = 3'b001 << pick_idx;
          busy_d  = 1'b1;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // finish takes precedence over a timeout landing in the same cycle
        if (finish) begin
          gnt_d   = 3'b000;
          busy_d  = 1'b0;
          state_d = S_GAP;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          gnt_d     = 3'b000;
          busy_d    = 1'b0;
          tmo_err_d = 1'b1;
          tmo_id_d  = ptr_q;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 3'b000;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd2;
      cnt_q     <= '0;
      gnt_q     <= 3'b000;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_id_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      tmo_err_q <= tmo_err_d;
      tmo_id_q  <= tmo_id_d;
    end
  end

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign gnt2    = gnt_q[2];
  assign sel     = gnt_q;
  assign busy    = busy_q;
  assign tmo_err = tmo_err_q;
  assign tmo_id  = tmo_id_q;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed bench for rr_arbiter3 with an 8-cycle watchdog.
// Inputs change 1ns after posedge; outputs are read at that point or on the negedge.
module tb_rr_arbiter3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, req2;
  logic [2:0] req_mask;
  logic       finish;
  logic       gnt0, gnt1, gnt2;
  logic [2:0] sel;
  logic       busy;
  logic       tmo_err;
  logic [1:0] tmo_id;

  int tests_run    = 0;
  int tests_failed = 0;

  rr_arbiter3 #(.TMO_W(10), .TMO_CYC(8), .TMO_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .req2(req2),
    .req_mask(req_mask), .finish(finish),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .sel(sel), .busy(busy), .tmo_err(tmo_err), .tmo_id(tmo_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
    req2     = 1'b0;
    req_mask = 3'b000;
    finish   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Structural invariants checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      tests_run++;
      if (sel !== {gnt2, gnt1, gnt0} || busy !== (|sel) || !$onehot0(sel)) begin
        tests_failed++;
        $display("FAIL invariant t=%0t sel=%b gnt=%b%b%b busy=%b", $time, sel, gnt2, gnt1, gnt0, busy);
      end
    end
  end

  task automatic test_reset();
    rst_n    = 1'b0;
    req0     = 1'b1;
    req1     = 1'b1;
    req2     = 1'b1;
    req_mask = 3'b000;
    finish   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({gnt2, gnt1, gnt0, sel, busy, tmo_err, tmo_id} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got gnt=%b%b%b sel=%b busy=%b tmo_err=%b tmo_id=%0d exp all 0",
               gnt2, gnt1, gnt0, sel, busy, tmo_err, tmo_id);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    // finish seen while idle must not do anything
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tests_run++;
    if (sel !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_finish sel=%b busy=%b exp 000/0", sel, busy);
    end
    req0 = 1'b1;
    tick();
    tests_run++;
    if (gnt0 !== 1'b1 || sel !== 3'b001 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_grant gnt0=%b sel=%b busy=%b exp 1/001/1", gnt0, sel, busy);
    end
    repeat (3) tick();
    tests_run++;
    if (sel !== 3'b001) begin
      tests_failed++;
      $display("FAIL basic_hold sel=%b exp 001", sel);
    end
    finish = 1'b1;
    req0   = 1'b0;
    tick();
    finish = 1'b0;
    tests_run++;
    if (gnt0 !== 1'b0 || sel !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_release gnt0=%b sel=%b busy=%b exp 0/000/0", gnt0, sel, busy);
    end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel [4];
    exp_sel[0] = 3'b001;
    exp_sel[1] = 3'b010;
    exp_sel[2] = 3'b100;
    exp_sel[3] = 3'b001;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    req2 = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      tests_run++;
      if (sel !== exp_sel[g]) begin
        tests_failed++;
        $display("FAIL rr_order grant %0d sel=%b exp %b", g, sel, exp_sel[g]);
      end
      repeat (3) tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      tests_run++;
      if (sel !== 3'b000) begin
        tests_failed++;
        $display("FAIL rr_release grant %0d sel=%b exp 000", g, sel);
      end
      tick();
      tests_run++;
      if (sel !== 3'b000) begin
        tests_failed++;
        $display("FAIL rr_gap grant %0d sel=%b exp 000", g, sel);
      end
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
    repeat (3) tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_mask();
    do_reset();
    req_mask = 3'b001;
    req0     = 1'b1;
    req1     = 1'b1;
    tick();
    tests_run++;
    if (sel !== 3'b010) begin
      tests_failed++;
      $display("FAIL mask_grant sel=%b exp 010", sel);
    end
    // masking the holder mid-grant must not drop it
    req_mask = 3'b011;
    repeat (2) tick();
    tests_run++;
    if (sel !== 3'b010) begin
      tests_failed++;
      $display("FAIL mask_midgrant sel=%b exp 010", sel);
    end
    finish = 1'b1;
    req1   = 1'b0;
    tick();
    finish   = 1'b0;
    req_mask = 3'b000;
    tests_run++;
    if (sel !== 3'b000) begin
      tests_failed++;
      $display("FAIL mask_release sel=%b exp 000", sel);
    end
    tick();
    tick();
    tests_run++;
    if (sel !== 3'b001) begin
      tests_failed++;
      $display("FAIL mask_cleared_wrap sel=%b exp 001", sel);
    end
    req0   = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req2 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (sel !== 3'b100 || tmo_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL tmo_hold cycle %0d sel=%b tmo_err=%b exp 100/0", i, sel, tmo_err);
      end
      tick();
    end
    tests_run++;
    if (sel !== 3'b000 || busy !== 1'b0 || tmo_err !== 1'b1 || tmo_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL tmo_release sel=%b busy=%b tmo_err=%b tmo_id=%0d exp 000/0/1/2",
               sel, busy, tmo_err, tmo_id);
    end
    tick();
    tests_run++;
    if (tmo_err !== 1'b0 || tmo_id !== 2'd2 || sel !== 3'b000) begin
      tests_failed++;
      $display("FAIL tmo_pulse_end tmo_err=%b tmo_id=%0d sel=%b exp 0/2/000", tmo_err, tmo_id, sel);
    end
    tick();
    tests_run++;
    if (sel !== 3'b100) begin
      tests_failed++;
      $display("FAIL tmo_rearb sel=%b exp 100", sel);
    end
    req2   = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tests_run++;
    if (sel !== 3'b000 || tmo_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_rearb_release sel=%b tmo_err=%b exp 000/0", sel, tmo_err);
    end
    repeat (2) tick();
  endtask

  // Runs straight after test_timeout so tmo_id still holds 2.
  task automatic test_finish_at_timeout();
    req1 = 1'b1;
    tick();
    tests_run++;
    if (sel !== 3'b010) begin
      tests_failed++;
      $display("FAIL fat_grant sel=%b exp 010", sel);
    end
    repeat (7) tick();
    finish = 1'b1;
    req1   = 1'b0;
    tick();
    finish = 1'b0;
    tests_run++;
    if (sel !== 3'b000 || tmo_err !== 1'b0 || tmo_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL fat_release sel=%b tmo_err=%b tmo_id=%0d exp 000/0/2", sel, tmo_err, tmo_id);
    end
    tick();
    tests_run++;
    if (tmo_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL fat_no_pulse tmo_err=%b exp 0", tmo_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req1 = 1'b1;
    tick();
    tests_run++;
    if (sel !== 3'b010) begin
      tests_failed++;
      $display("FAIL rmid_grant sel=%b exp 010", sel);
    end
    rst_n = 1'b0;
    req1  = 1'b0;
    #1;
    tests_run++;
    if (gnt1 !== 1'b0 || sel !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_async_clear gnt1=%b sel=%b busy=%b exp 0/000/0", gnt1, sel, busy);
    end
    tick();
    rst_n = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    tick();
    tests_run++;
    if (sel !== 3'b001) begin
      tests_failed++;
      $display("FAIL rmid_ptr_reset sel=%b exp 001", sel);
    end
    req0   = 1'b0;
    req1   = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_mask();
    test_timeout();
    test_finish_at_timeout();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
